arith_expr_calc: RTL and testbench
==================================

Name: arith_expr_calc

Overview:
- Serial ASCII arithmetic-expression calculator. Accepts one character per clock: single-digit hex operands, `+ - *`, parentheses, terminated by `=`.
- On termination it checks parenthesis balance, evaluates with standard precedence, and reports a 7-bit result with a one-cycle valid pulse.
- Sits behind a character-stream source that supplies a new expression after each valid pulse.

Parameters:
- MAX_LEN, 32, maximum characters per expression including `=`.
- DW, 16, internal two's-complement arithmetic width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ready  input  1  one-cycle pulse marking that ascii_in carries the first character of a new expression.
- ascii_in  input  8  ASCII character, sampled on rising clk.
- valid  output  1  one-cycle pulse: result and parenthesesLegal are valid.
- result  output  7  expression value, low 7 bits.
- parenthesesLegal  output  1  1 = parentheses balanced and properly nested.

Behaviour:
- Reset (async, rst=1): valid=0, result=0, parenthesesLegal=0, all stacks/counters cleared, state IDLE.
- Character set:
  - `0`-`9` → values 0-9; `a`-`f` → values 10-15.
  - Every operand is exactly one character; no multi-digit numbers.
  - Operators `+` (0x2B), `-` (0x2D), `*` (0x2A); `(` (0x28), `)` (0x29); `=` (0x3D) terminates.
  - Any other code is ignored.
- Capture:
  - A rising edge with ready=1 starts a new expression: capture ascii_in as character 0 and clear all previous state.
  - Each following cycle, capture one character until `=` is captured.
  - After `=`, ignore ascii_in, which the source holds at `=`.
  - ready=1 in any state aborts current work and restarts capture with that character.
  - Characters beyond MAX_LEN are dropped; `=` still terminates.
- Legality:
  - Depth counter: +1 on `(`, −1 on `)`.
  - parenthesesLegal=1 iff depth never goes negative and equals 0 at `=`.
  - Illegal expression: result=0, parenthesesLegal=0, valid still pulses.
- Evaluation (legal expressions):
  - `*` binds tighter than `+`/`-`; `+`/`-` are left-associative; parentheses override.
  - Implementation: infix-to-postfix conversion with an operator stack, then postfix evaluation with an operand stack.
  - Conversion may run on the fly during capture or after `=`.
  - All arithmetic in DW-bit two's complement, wrapping.
  - result = value[6:0].
  - Well-formed expressions only (no unary minus); results of interest are 0..99.
- States: IDLE → CAPTURE (on ready) → FLUSH (pop remaining operators) → EVAL (one postfix token per cycle) → DONE (valid=1 for exactly one cycle) → IDLE.
- Latency:
  - valid asserts no later than 2*MAX_LEN+4 cycles after `=` is sampled.
  - valid is never high two consecutive cycles.
- Holding: result and parenthesesLegal hold their values after valid until the next DONE or reset.
- Back-to-back: ready may arrive the second cycle after valid; the new expression must not see any previous stack contents.

Test Plan:
- Reset mid-capture of `3+4=`: async rst → valid/result/parenthesesLegal=0 immediately; next ready starts clean.
- `2+3*4=` → valid pulse, result=14, parenthesesLegal=1; `(2+3)*4=` → result=20.
- `f*6-a=` → result=80; `9-3-2=` → result=4 (left-associativity).
- `((a+b)*(c-7))-f=` → result=90, parenthesesLegal=1.
- Illegal: `(1+2=` and `1+2)*(3=` → parenthesesLegal=0, result=0, single valid pulse each.
- 20 back-to-back random legal/illegal expressions, ready issued two cycles after each valid → every answer matches a software golden model (precedence, 16-bit wrap, low 7 bits); each valid is one cycle; all complete well under 5000 total cycles.

Source files
------------

// File: rtl/arith_expr_calc.sv
// Serial ASCII arithmetic-expression calculator.
// Characters arrive one per clock. Operands are single hex digits. The operators are + - * and
// parentheses, and '=' ends the expression. Infix is converted to postfix on the fly while
// characters are captured. Leftover operators are flushed after '='. The postfix queue is then
// evaluated one token per cycle on an operand stack.
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   ready            pulse: ascii_in carries the first character of a new expression
//   ascii_in         ASCII character, sampled on rising clk
//   valid            one-cycle pulse when result/parenthesesLegal are updated
//   result           low 7 bits of the expression value (0 when parentheses are illegal)
//   parenthesesLegal 1 when parentheses are balanced and never close below depth zero
module arith_expr_calc #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned DW      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] ascii_in,
    output logic       valid,
    output logic [6:0] result,
    output logic       parenthesesLegal
);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MaxLenC = CW'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StCapture, StFlush, StEval, StDone} state_e;
    typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpLp} op_e;
    typedef enum logic [2:0] {CkNone, CkDigit, CkAdd, CkSub, CkMul, CkLp, CkRp, CkEq} chr_e;

    state_e        state;
    op_e           op_stk  [MAX_LEN];
    logic [4:0]    pf_q    [MAX_LEN];  // postfix token: {is_op, operand value or op code}
    logic [DW-1:0] val_stk [MAX_LEN];
    logic [CW-1:0] op_sp, pf_cnt, pf_rd, val_sp, len, depth;
    logic          bad;

    // Character classification
    chr_e       kind;
    logic [3:0] digit;
    always_comb begin
        kind  = CkNone;
        digit = 4'd0;
        if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
            kind  = CkDigit;
            digit = ascii_in[3:0];
        end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
            kind  = CkDigit;
            digit = ascii_in[3:0] + 4'd9;
        end else begin
            case (ascii_in)
                8'h2B:   kind = CkAdd;
                8'h2D:   kind = CkSub;
                8'h2A:   kind = CkMul;
                8'h28:   kind = CkLp;
                8'h29:   kind = CkRp;
                8'h3D:   kind = CkEq;
                default: kind = CkNone;
            endcase
        end
    end

    // Capture / conversion step. ready forces a clean base so the first character never sees
    // stale stack contents.
    logic          take, drop, pop1, pop2, fl_emit, cap_bad, cap_eq;
    logic [CW-1:0] b_sp, b_cnt, b_len, b_depth, pops;
    logic [CW-1:0] cap_sp, cap_cnt, cap_len, cap_depth, push_idx;
    op_e           top1, top2, push_op;
    logic          push_en, pf_we0, pf_we1;
    logic [4:0]    pf_d0, pf_d1;

    assign take = ready || (state == StCapture);

    always_comb begin
        b_sp    = ready ? '0 : op_sp;
        b_cnt   = ready ? '0 : pf_cnt;
        b_len   = ready ? '0 : len;
        b_depth = ready ? '0 : depth;
        top1    = OpLp;
        top2    = OpLp;
        if (b_sp >= CW'(1)) top1 = op_stk[AW'(b_sp - CW'(1))];
        if (b_sp >= CW'(2)) top2 = op_stk[AW'(b_sp - CW'(2))];
        // Within one nesting level the stack holds at most [+/-, *], so two pops always suffice
        pop1 = (b_sp != '0) && (top1 != OpLp);
        pop2 = pop1 && (b_sp >= CW'(2)) && (top2 != OpLp);
        pops = CW'(pop1) + CW'(pop2);
        drop = (b_len == MaxLenC) && (kind != CkEq);

        cap_sp    = b_sp;
        cap_cnt   = b_cnt;
        cap_depth = b_depth;
        cap_bad   = ready ? 1'b0 : bad;
        cap_len   = drop ? b_len : b_len + CW'(1);
        cap_eq    = 1'b0;
        push_en   = 1'b0;
        push_idx  = b_sp;
        push_op   = OpAdd;
        pf_we0    = 1'b0;
        pf_we1    = 1'b0;
        pf_d0     = {3'b100, top1};
        pf_d1     = {3'b100, top2};
        fl_emit   = 1'b0;

        if (take && !drop) begin
            unique case (kind)
                CkDigit: begin
                    pf_we0  = 1'b1;
                    pf_d0   = {1'b0, digit};
                    cap_cnt = b_cnt + CW'(1);
                end
                CkLp: begin
                    push_en   = 1'b1;
                    push_op   = OpLp;
                    cap_sp    = b_sp + CW'(1);
                    cap_depth = b_depth + CW'(1);
                end
                CkMul: begin
                    if (b_sp != '0 && top1 == OpMul) begin
                        // Emit the pending '*' and leave the new one in its slot
                        pf_we0  = 1'b1;
                        cap_cnt = b_cnt + CW'(1);
                    end else begin
                        push_en = 1'b1;
                        push_op = OpMul;
                        cap_sp  = b_sp + CW'(1);
                    end
                end
                CkAdd, CkSub: begin
                    pf_we0   = pop1;
                    pf_we1   = pop2;
                    cap_cnt  = b_cnt + pops;
                    push_en  = 1'b1;
                    push_op  = (kind == CkAdd) ? OpAdd : OpSub;
                    push_idx = b_sp - pops;
                    cap_sp   = b_sp - pops + CW'(1);
                end
                CkRp: begin
                    if (b_depth == '0) begin
                        cap_bad = 1'b1;
                    end else begin
                        cap_depth = b_depth - CW'(1);
                        pf_we0    = pop1;
                        pf_we1    = pop2;
                        cap_cnt   = b_cnt + pops;
                        cap_sp    = (b_sp > pops) ? b_sp - pops - CW'(1) : '0;
                    end
                end
                CkEq: begin
                    cap_eq = 1'b1;
                    if (b_depth != '0) cap_bad = 1'b1;
                end
                default: ;
            endcase
        end else if (!take && state == StFlush && op_sp != '0 && top1 != OpLp) begin
            pf_we0  = 1'b1;
            fl_emit = 1'b1;
        end
    end

    // Postfix evaluation step
    logic [4:0]    tok;
    logic [DW-1:0] opa, opb, val_d;
    logic          val_we;
    logic [CW-1:0] val_idx, ev_sp;
    always_comb begin
        tok     = pf_q[AW'(pf_rd)];
        opa     = val_stk[AW'(val_sp - CW'(2))];
        opb     = val_stk[AW'(val_sp - CW'(1))];
        val_we  = 1'b0;
        val_idx = val_sp;
        val_d   = '0;
        ev_sp   = val_sp;
        if (state == StEval && !ready && pf_rd != pf_cnt) begin
            if (!tok[4]) begin
                val_we = 1'b1;
                val_d  = {{(DW-4){1'b0}}, tok[3:0]};
                ev_sp  = val_sp + CW'(1);
            end else if (val_sp >= CW'(2)) begin
                val_we  = 1'b1;
                val_idx = val_sp - CW'(2);
                ev_sp   = val_sp - CW'(1);
                case (op_e'(tok[1:0]))
                    OpAdd:   val_d = opa + opb;
                    OpSub:   val_d = opa - opb;
                    OpMul:   val_d = opa * opb;
                    default: val_d = '0;
                endcase
            end
        end
    end

    // Stack and queue storage; contents are only meaningful below their pointers
    always_ff @(posedge clk) begin
        if (push_en) op_stk[AW'(push_idx)] <= push_op;
        if (pf_we0) pf_q[AW'(b_cnt)] <= pf_d0;
        if (pf_we1) pf_q[AW'(b_cnt + CW'(1))] <= pf_d1;
        if (val_we) val_stk[AW'(val_idx)] <= val_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            op_sp            <= '0;
            pf_cnt           <= '0;
            pf_rd            <= '0;
            val_sp           <= '0;
            len              <= '0;
            depth            <= '0;
            bad              <= 1'b0;
            valid            <= 1'b0;
            result           <= 7'd0;
            parenthesesLegal <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (take) begin
                op_sp  <= cap_sp;
                pf_cnt <= cap_cnt;
                len    <= cap_len;
                depth  <= cap_depth;
                bad    <= cap_bad;
                pf_rd  <= '0;
                val_sp <= '0;
                if (!cap_eq) begin
                    state <= StCapture;
                end else if (cap_bad) begin
                    state            <= StDone;
                    valid            <= 1'b1;
                    result           <= 7'd0;
                    parenthesesLegal <= 1'b0;
                end else begin
                    state <= StFlush;
                end
            end else begin
                case (state)
                    StFlush: begin
                        if (op_sp != '0) begin
                            op_sp  <= op_sp - CW'(1);
                            pf_cnt <= pf_cnt + CW'(fl_emit);
                        end else begin
                            state <= StEval;
                        end
                    end
                    StEval: begin
                        if (pf_rd == pf_cnt) begin
                            state            <= StDone;
                            valid            <= 1'b1;
                            result           <= (val_sp != '0) ? val_stk[0][6:0] : 7'd0;
                            parenthesesLegal <= 1'b1;
                        end else begin
                            pf_rd  <= pf_rd + CW'(1);
                            val_sp <= ev_sp;
                        end
                    end
                    StDone:  state <= StIdle;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_arith_expr_calc.sv
// Directed self-checking bench for arith_expr_calc.
module tb_arith_expr_calc;
    localparam int unsigned MaxLen = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] ascii_in;
    logic       valid;
    logic [6:0] result;
    logic       parenthesesLegal;

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    arith_expr_calc #(
        .MAX_LEN(MaxLen),
        .DW     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ready           (ready),
        .ascii_in        (ascii_in),
        .valid           (valid),
        .result          (result),
        .parenthesesLegal(parenthesesLegal)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one expression starting at a negedge, wait for valid, check the answer and the
    // single-cycle pulse. Returns at the negedge after valid, so the next ready lands two
    // cycles after valid.
    task automatic run_expr(input string expr, input int exp_res, input int exp_legal);
        bit got_valid = 1'b0;
        int waited = 0;
        ready    = 1'b1;
        ascii_in = expr[0];
        for (int i = 1; i < expr.len(); i++) begin
            @(negedge clk);
            ready    = 1'b0;
            ascii_in = expr[i];
        end
        @(negedge clk);
        ready = 1'b0;
        while (!got_valid && waited < 2 * MaxLen + 5) begin
            if (valid) got_valid = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check_eq({expr, " valid"}, int'(got_valid), 1);
        if (got_valid) begin
            check_eq({expr, " result"}, int'(result), exp_res);
            check_eq({expr, " legal"}, int'(parenthesesLegal), exp_legal);
            @(negedge clk);
            check_eq({expr, " pulse"}, int'(valid), 0);
        end
    endtask

    string vec_expr [20] = '{
        "1+2*3-4=", "(1+2=", "1+2)*(3=", "8*(7-5)+9=", "1-2=",
        "f*f*f*f=", ")(=", "a*b+c*d=", "((((9))))=", "e-(3+4)*2=",
        "2*3*4-5=", "(9-(4-2))*3=", "7+(2*(3+1)=", "c+d-e+f=", "5 *x 4=",
        "9*9+9*2=", "0=", "(b)*(6)-(a)=", "3-4-5=", "(8+1)*(8-1)+(2="
    };
    int vec_res [20] = '{3, 0, 0, 25, 127, 65, 0, 10, 9, 0,
                         19, 21, 0, 26, 20, 99, 0, 56, 122, 0};
    int vec_leg [20] = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 1,
                         1, 1, 0, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        int start_cyc;
        rst      = 1'b1;
        ready    = 1'b0;
        ascii_in = 8'h3D;
        #1;
        check_eq("reset valid", int'(valid), 0);
        check_eq("reset result", int'(result), 0);
        check_eq("reset legal", int'(parenthesesLegal), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_expr("2+3*4=", 14, 1);
        repeat (3) @(negedge clk);
        check_eq("hold result", int'(result), 14);
        check_eq("hold legal", int'(parenthesesLegal), 1);
        check_eq("hold valid", int'(valid), 0);

        // Asynchronous reset in the middle of "3+4="
        ready    = 1'b1;
        ascii_in = "3";
        @(negedge clk);
        ready    = 1'b0;
        ascii_in = "+";
        #2 rst = 1'b1;
        #1;
        check_eq("midrst result", int'(result), 0);
        check_eq("midrst legal", int'(parenthesesLegal), 0);
        check_eq("midrst valid", int'(valid), 0);
        @(negedge clk);
        rst      = 1'b0;
        ascii_in = "=";
        repeat (2) @(negedge clk);
        check_eq("midrst idle", int'(valid), 0);
        run_expr("3+4=", 7, 1);

        run_expr("(2+3)*4=", 20, 1);
        run_expr("f*6-a=", 80, 1);
        run_expr("9-3-2=", 4, 1);
        run_expr("((a+b)*(c-7))-f=", 90, 1);
        run_expr("(1+2=", 0, 0);
        run_expr("1+2)*(3=", 0, 0);
        // Exactly MAX_LEN characters including '='
        run_expr("f*f*f*f+1+1+1+1+1+1+1+1+1+1+1+1=", 77, 1);

        start_cyc = cycles;
        for (int i = 0; i < 20; i++) run_expr(vec_expr[i], vec_res[i], vec_leg[i]);
        check_eq("b2b cycle budget", int'((cycles - start_cyc) < 5000), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
